// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
//
// Pipeline control sequencer for the 5-stage core. Decodes which source
// registers the ID-stage instruction reads, detects load-use hazards against
// the load in EX, freezes the pipe while the data cache services a miss, and
// flushes IF/ID on taken branches. Also runs a watchdog on cache stalls.
//
// Control outputs are combinational from the registered FSM state plus the
// current inputs. timeout_o is a registered sticky flag.
//
// Parameters
//   TIMEOUT  max consecutive mem_stall_i cycles before timeout_o sets (2..65535)
//   CNT_W    width of the performance counters (PERF_CNT_EN builds only)
//
// Ports
//   clk_i           in   core clock, rising edge
//   rst_i           in   synchronous reset, active-low
//   id_instr_i      in   [31:0] instruction in ID
//   idex_memread_i  in   instruction in EX is a load
//   idex_rd_i       in   [4:0] destination register of instruction in EX
//   branch_taken_i  in   beq in ID resolved taken this cycle
//   mem_stall_i     in   data cache busy; pipe must freeze
//   pc_write_o      out  PC may update
//   ifid_write_o    out  IF/ID may load
//   ifid_flush_o    out  IF/ID loads a NOP
//   idex_bubble_o   out  ID/EX loads all-zero control
//   stall_o         out  global freeze of EX/MEM and MEM/WB
//   timeout_o       out  sticky: cache stall exceeded TIMEOUT cycles
//   stall_cnt_o     out  [CNT_W-1:0] cycles with stall_o=1       (PERF_CNT_EN)
//   bubble_cnt_o    out  [CNT_W-1:0] cycles with idex_bubble_o=1 (PERF_CNT_EN)
//   flush_cnt_o     out  [CNT_W-1:0] cycles with ifid_flush_o=1  (PERF_CNT_EN)
//
// Build option: define PERF_CNT_EN to add the three performance counters.
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       id_instr_i,
    input  logic              idex_memread_i,
    input  logic [4:0]        idex_rd_i,
    input  logic              branch_taken_i,
    input  logic              mem_stall_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              stall_o,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
`endif
    output logic              timeout_o
);

    localparam int CNT_BITS = $clog2(TIMEOUT + 1);
    localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT);
    localparam logic [CNT_BITS-1:0] TIMEOUT_M1_C = CNT_BITS'(TIMEOUT - 1);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_BITS-1:0]  stall_cnt_r;
    logic                 timeout_r;

    logic [6:0]           opcode_s;
    logic [4:0]           rs1_s;
    logic [4:0]           rs2_s;
    logic                 use_rs1_s;
    logic                 use_rs2_s;
    logic                 hazard_s;
    logic                 hazard_en_s;

    logic                 pc_write_s;
    logic                 ifid_write_s;
    logic                 ifid_flush_s;
    logic                 idex_bubble_s;
    logic                 stall_s;

    // Instruction fields that play no part in hazard detection.
    logic                 unused_instr_bits_s;
    assign unused_instr_bits_s = ^{id_instr_i[31:25], id_instr_i[14:7]};

    assign opcode_s = id_instr_i[6:0];
    assign rs1_s    = id_instr_i[19:15];
    assign rs2_s    = id_instr_i[24:20];

    // Source-register usage decode; unknown opcodes (incl. X) read nothing.
    always_comb begin
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        case (opcode_s)
            OP_REG, OP_STORE, OP_BRANCH: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            OP_IMM, OP_LOAD: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b0;
            end
            default: begin
                use_rs1_s = 1'b0;
                use_rs2_s = 1'b0;
            end
        endcase
    end

    // Load-use hit; a load to x0 never creates a dependency.
    assign hazard_s = idex_memread_i && (idex_rd_i != 5'd0) &&
                      ((use_rs1_s && (idex_rd_i == rs1_s)) ||
                       (use_rs2_s && (idex_rd_i == rs2_s)));

    // Hazard check is masked for the cycle after a bubble so each load
    // inserts exactly one. MEMWAIT with the stall released behaves as RUN.
    always_comb begin
        hazard_en_s = 1'b1;
        case (state_r)
            ST_RUN:     hazard_en_s = 1'b1;
            ST_LDUSE:   hazard_en_s = 1'b0;
            ST_MEMWAIT: hazard_en_s = 1'b1;
            default:    hazard_en_s = 1'b1;
        endcase
    end

    // Next state and pipeline controls; priority: reset, cache stall,
    // load-use, taken branch.
    always_comb begin
        state_nxt_s   = ST_RUN;
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        stall_s       = 1'b0;
        if (!rst_i) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
            state_nxt_s   = ST_RUN;
        end else if (mem_stall_i) begin
            // Branch and hazard are deferred: ID is frozen and re-evaluates.
            stall_s       = 1'b1;
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            state_nxt_s   = ST_MEMWAIT;
        end else if (hazard_en_s && hazard_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
            state_nxt_s   = ST_LDUSE;
        end else if (branch_taken_i) begin
            ifid_flush_s  = 1'b1;
            state_nxt_s   = ST_RUN;
        end else begin
            state_nxt_s   = ST_RUN;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Cache-stall watchdog: saturating run-length counter plus sticky flag.
    // The flag sets on the edge that completes the TIMEOUT-th stall cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_r <= {CNT_BITS{1'b0}};
            timeout_r   <= 1'b0;
        end else if (mem_stall_i) begin
            if (stall_cnt_r != TIMEOUT_C) begin
                stall_cnt_r <= stall_cnt_r + CNT_BITS'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (stall_cnt_r >= TIMEOUT_M1_C) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end else begin
            stall_cnt_r <= {CNT_BITS{1'b0}};
            timeout_r   <= timeout_r;
        end
    end

    assign pc_write_o    = pc_write_s;
    assign ifid_write_o  = ifid_write_s;
    assign ifid_flush_o  = ifid_flush_s;
    assign idex_bubble_o = idex_bubble_s;
    assign stall_o       = stall_s;
    assign timeout_o     = timeout_r;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_r;
    logic [CNT_W-1:0] perf_bubble_r;
    logic [CNT_W-1:0] perf_flush_r;

    // Performance counters; wrap naturally, reset-forced bubbles not counted.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_stall_r  <= {CNT_W{1'b0}};
            perf_bubble_r <= {CNT_W{1'b0}};
            perf_flush_r  <= {CNT_W{1'b0}};
        end else begin
            perf_stall_r  <= perf_stall_r  + (stall_s       ? CNT_W'(1) : CNT_W'(0));
            perf_bubble_r <= perf_bubble_r + (idex_bubble_s ? CNT_W'(1) : CNT_W'(0));
            perf_flush_r  <= perf_flush_r  + (ifid_flush_s  ? CNT_W'(1) : CNT_W'(0));
        end
    end

    assign stall_cnt_o  = perf_stall_r;
    assign bubble_cnt_o = perf_bubble_r;
    assign flush_cnt_o  = perf_flush_r;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller (TIMEOUT=8).
// Output vector compared each cycle:
//   {pc_write, ifid_write, ifid_flush, idex_bubble, stall, timeout}
module tb_hazard_stall_controller;

    localparam int CNT_W = 32;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] id_instr_i;
    logic        idex_memread_i;
    logic [4:0]  idex_rd_i;
    logic        branch_taken_i;
    logic        mem_stall_i;
    logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stall_o, timeout_o;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_o, bubble_cnt_o, flush_cnt_o;
`endif

    hazard_stall_controller #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_instr_i     (id_instr_i),
        .idex_memread_i (idex_memread_i),
        .idex_rd_i      (idex_rd_i),
        .branch_taken_i (branch_taken_i),
        .mem_stall_i    (mem_stall_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .stall_o        (stall_o),
`ifdef PERF_CNT_EN
        .stall_cnt_o    (stall_cnt_o),
        .bubble_cnt_o   (bubble_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
`endif
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected output patterns
    localparam logic [5:0] RUNO = 6'b110000;  // all writes, nothing else
    localparam logic [5:0] LDUO = 6'b000100;  // load-use bubble
    localparam logic [5:0] STLO = 6'b000010;  // cache stall freeze
    localparam logic [5:0] BRO  = 6'b111000;  // taken-branch flush
    localparam logic [5:0] RSTO = 6'b000100;  // held in reset
    localparam logic [5:0] TO   = 6'b000001;  // timeout flag bit

    // Instructions
    localparam logic [31:0] ADD_X6_X5_X1 = 32'h00128333;
    localparam logic [31:0] ADD_X6_X0_X0 = 32'h00000333;
    localparam logic [31:0] SW_X5_0_X1   = 32'h0050A023;
    localparam logic [31:0] LUI_X5       = 32'h005282B7;  // imm bits alias x5 in rs1/rs2 slots
    localparam logic [31:0] BEQ_X0_X0    = 32'h00000063;

    typedef struct packed {
        logic        rst;
        logic        ms;
        logic        mr;
        logic        br;
        logic [4:0]  rd;
        logic [31:0] instr;
        logic [5:0]  exp;
    } step_t;

    logic [5:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic step_t mk(input logic rst, input logic ms, input logic mr, input logic br,
                                 input logic [4:0] rd, input logic [31:0] instr, input logic [5:0] e);
        step_t s;
        s.rst = rst; s.ms = ms; s.mr = mr; s.br = br; s.rd = rd; s.instr = instr; s.exp = e;
        return s;
    endfunction

    // Drive one cycle of stimulus and queue the output expected for it.
    task automatic drive(input step_t s);
        rst_i          = s.rst;
        mem_stall_i    = s.ms;
        idex_memread_i = s.mr;
        branch_taken_i = s.br;
        idex_rd_i      = s.rd;
        id_instr_i     = s.instr;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        step_t s[$];
        logic [5:0] got, e;
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RSTO));
        s.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, ADD_X6_X5_X1, RSTO));
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RUNO));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk_i);
            got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stall_o, timeout_o};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL reset step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_load_use();
        step_t s[$];
        logic [5:0] got, e;
        s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, ADD_X6_X5_X1, LDUO)); // hazard on rs1
        s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, ADD_X6_X5_X1, RUNO)); // one bubble only
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X5_X1, RUNO));
        s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, SW_X5_0_X1,   LDUO)); // hazard on rs2
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, SW_X5_0_X1,   RUNO));
        s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, ADD_X6_X5_X1, LDUO)); // rs2=x1
        s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, ADD_X6_X5_X1, BRO));  // LDUSE still flushes
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk_i);
            got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stall_o, timeout_o};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL load_use step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_no_hazard();
        step_t s[$];
        logic [5:0] got, e;
        s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, ADD_X6_X0_X0, RUNO)); // lw x0
        s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, LUI_X5,       RUNO)); // lui reads nothing
        s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd6, ADD_X6_X5_X1, RUNO)); // rd only matches dest
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, ADD_X6_X5_X1, RUNO)); // not a load
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'bx,        RUNO)); // invalid ID instr
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk_i);
            got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stall_o, timeout_o};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL no_hazard step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_branch_stall();
        step_t s[$];
        logic [5:0] got, e;
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, BEQ_X0_X0, BRO));
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, BEQ_X0_X0, RUNO));
        for (int k = 0; k < 4; k++)
            s.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, BEQ_X0_X0, STLO));
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, BEQ_X0_X0, BRO));    // deferred flush
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, BEQ_X0_X0, RUNO));
        s.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, ADD_X6_X5_X1, STLO)); // stall beats hazard
        s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, ADD_X6_X5_X1, LDUO)); // no dead cycle
        s.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, ADD_X6_X5_X1, STLO)); // LDUSE -> MEMWAIT
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X5_X1, RUNO));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk_i);
            got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stall_o, timeout_o};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL branch_stall step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_timeout();
        step_t s[$];
        logic [5:0] got, e;
        for (int k = 0; k < 7; k++)  // one short of TIMEOUT, then release
            s.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, STLO));
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RUNO));
        for (int k = 1; k <= 10; k++)  // flag visible after the 8th stall edge
            s.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, (k >= 9) ? (STLO | TO) : STLO));
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RUNO | TO));
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RUNO | TO));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk_i);
            got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stall_o, timeout_o};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL timeout step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t s[$];
        logic [5:0] got, e;
        s.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, STLO | TO)); // enter MEMWAIT
        s.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RSTO | TO)); // flag clears at edge
        s.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RSTO));
        s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, ADD_X6_X5_X1, LDUO));      // back in RUN
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RUNO));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk_i);
            got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stall_o, timeout_o};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL reset_mid_stall step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk_i); #1;
        end
    endtask

`ifdef PERF_CNT_EN
    task automatic test_perf_counters();
        step_t s[$];
        logic [5:0] got, e;
        logic [3*CNT_W-1:0] pq[$];
        logic [3*CNT_W-1:0] pgot, pexp;
        s.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RSTO));
        for (int k = 0; k < 3; k++) begin
            s.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, ADD_X6_X5_X1, LDUO));
            s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RUNO));
        end
        for (int k = 0; k < 2; k++)
            s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, BEQ_X0_X0, BRO));
        for (int k = 0; k < 5; k++)
            s.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, STLO));
        s.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, ADD_X6_X0_X0, RUNO));
        pq.push_back({CNT_W'(5), CNT_W'(3), CNT_W'(2)});
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk_i);
            got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stall_o, timeout_o};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL perf step %0d: got %b expected %b", i, got, e);
            end
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        pgot = {stall_cnt_o, bubble_cnt_o, flush_cnt_o};
        pexp = pq.pop_front();
        n_cmp++;
        if (pgot !== pexp) begin
            n_bad++;
            $display("FAIL perf_counts: got stall=%0d bubble=%0d flush=%0d expected 5/3/2",
                     stall_cnt_o, bubble_cnt_o, flush_cnt_o);
        end
    endtask
`endif

    initial begin
        rst_i          = 1'b0;
        mem_stall_i    = 1'b0;
        idex_memread_i = 1'b0;
        branch_taken_i = 1'b0;
        idex_rd_i      = 5'd0;
        id_instr_i     = 32'h0000_0013;
        @(posedge clk_i); #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_stall();
        test_timeout();
        test_reset_mid_stall();
`ifdef PERF_CNT_EN
        test_perf_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
